// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single main-memory port between the instruction-fetch requester (I)
//   and the data-access requester (D). Only one transaction is in flight at a time.
//   Every transaction is followed by at least one IDLE cycle.
//
// Optional feature macro: MEM_ARB_RR_EN
//   undefined : fixed priority, D wins simultaneous requests (I can starve)
//   defined   : round-robin on ties, using a 1-bit last-owner register (reset = I)
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   i_req, i_addr            I request / address (held until i_done)
//   i_done, i_rdata          I completion pulse / read data
//   d_req, d_we, d_addr,
//   d_wdata                  D request / write enable / address / write data
//   d_done, d_rdata          D completion pulse / read data
//   mem_sel                  address/write-data mux select, 0=I 1=D
//   mem_req, mem_we,
//   mem_addr, mem_wdata      memory request side
//   mem_ready, mem_rdata     memory completion / read data
//
// state  | meaning
// IDLE   | no transaction; arbitrate pending requests
// BUSY_I | I owns the memory port, waiting for mem_ready
// BUSY_D | D owns the memory port, waiting for mem_ready

module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_sel,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t state;
    logic   grant_d;
    logic   busy_i;
    logic   busy_d;

`ifdef MEM_ARB_RR_EN
    logic   last_owner;   // 0 = I, 1 = D

    // On a tie, the requester that did not own the port last time wins.
    always_comb begin
        grant_d = d_req & (~i_req | ~last_owner);
    end
`else
    always_comb begin
        grant_d = d_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_sel <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_owner <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_req | d_req) begin
                        state   <= grant_d ? BUSY_D : BUSY_I;
                        mem_req <= 1'b1;
                        mem_sel <= grant_d;
`ifdef MEM_ARB_RR_EN
                        last_owner <= grant_d;
`endif
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (mem_ready) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_sel <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    mem_sel <= 1'b0;
                end
            endcase
        end
    end

    assign busy_i = (state == BUSY_I);
    assign busy_d = (state == BUSY_D);

    // A reset cycle abandons the transaction, so completion is suppressed there.
    assign i_done = busy_i & mem_ready & ~reset;
    assign d_done = busy_d & mem_ready & ~reset;

    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    // Owner inputs are not latched; the requester holds them stable while req is high.
    assign mem_we    = busy_d & d_we;
    assign mem_addr  = busy_d ? d_addr : (busy_i ? i_addr : '0);
    assign mem_wdata = busy_d ? d_wdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        mem_sel;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    int tests = 0;
    int fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_sel(mem_sel), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    txn_t        i_q[$];
    txn_t        d_q[$];
    logic        grants[$];             // 1 = D, 0 = I, in grant order
    logic [31:0] mem[logic [31:0]];     // memory contents as seen by the responder
    logic [31:0] shadow[logic [31:0]];  // D's own view of what it has written

    logic mon_en     = 1'b0;
    logic mem_stall  = 1'b0;
    logic idle_force = 1'b0;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a ^ 32'hC3A5_5A3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: random latency 0..4, occasional stray mem_ready while idle.
    initial begin
        int lat = 0;
        forever begin
            @(posedge clk);
            #2;
            mem_ready = 1'b0;
            if (mem_stall) begin
                mem_ready = 1'b0;
            end else if (mem_req === 1'b1) begin
                if (lat == 0) begin
                    mem_ready = 1'b1;
                    if (mem_we) begin
                        mem[mem_addr] = mem_wdata;
                        mem_rdata = $urandom;
                    end else begin
                        mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : init_val(mem_addr);
                    end
                    lat = $urandom_range(0, 4);
                end else begin
                    lat--;
                end
            end else if (idle_force || $urandom_range(0, 7) == 0) begin
                mem_ready = 1'b1;
                mem_rdata = $urandom;
            end
        end
    end

    // Reference model + scoreboard monitor: port is either free or owned by one requester.
    initial begin
        logic m_busy  = 1'b0;
        logic m_owner = 1'b0;
        logic m_last  = 1'b0;
        logic m_fresh = 1'b1;
        logic win;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("mem_req", {31'd0, mem_req}, {31'd0, m_busy});
                chk("i_done", {31'd0, i_done}, {31'd0, m_busy & ~m_owner & mem_ready & ~reset});
                chk("d_done", {31'd0, d_done}, {31'd0, m_busy & m_owner & mem_ready & ~reset});
                if (m_busy) begin
                    chk("mem_sel", {31'd0, mem_sel}, {31'd0, m_owner});
                    if (!m_owner) begin
                        if (i_q.size() == 0) begin
                            tests++; fail++;
                            $display("FAIL i_queue: got I busy, expected an outstanding I request");
                        end else begin
                            chk("i_mem_addr", mem_addr, i_q[0].addr);
                            chk("i_mem_we", {31'd0, mem_we}, 32'd0);
                            if (mem_ready && !reset) begin
                                chk("i_rdata", i_rdata, i_q[0].rdata);
                                void'(i_q.pop_front());
                            end
                        end
                    end else begin
                        if (d_q.size() == 0) begin
                            tests++; fail++;
                            $display("FAIL d_queue: got D busy, expected an outstanding D request");
                        end else begin
                            chk("d_mem_addr", mem_addr, d_q[0].addr);
                            chk("d_mem_we", {31'd0, mem_we}, {31'd0, d_q[0].we});
                            if (d_q[0].we) chk("d_mem_wdata", mem_wdata, d_q[0].wdata);
                            if (mem_ready && !reset) begin
                                if (!d_q[0].we) chk("d_rdata", d_rdata, d_q[0].rdata);
                                void'(d_q.pop_front());
                            end
                        end
                    end
                end else begin
                    chk("idle_mem_addr", mem_addr, 32'd0);
                    chk("idle_mem_wdata", mem_wdata, 32'd0);
                    chk("idle_mem_we", {31'd0, mem_we}, 32'd0);
                    if (m_fresh) chk("reset_mem_sel", {31'd0, mem_sel}, 32'd0);
                end

                if (reset) begin
                    m_busy = 1'b0; m_last = 1'b0; m_fresh = 1'b1;
                end else if (m_busy) begin
                    if (mem_ready) m_busy = 1'b0;
                end else if (i_req || d_req) begin
                    if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
                        win = ~m_last;
`else
                        win = 1'b1;
`endif
                    end else begin
                        win = d_req;
                    end
                    m_busy = 1'b1; m_owner = win; m_last = win; m_fresh = 1'b0;
                    grants.push_back(win);
                end
            end
        end
    end

    task automatic wait_done(input logic is_d);
        bit got = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if ((is_d ? d_done : i_done) === 1'b1) begin got = 1; break; end
        end
        if (!got) begin
            tests++; fail++;
            $display("FAIL %s_timeout: got no done within 200 cycles, expected done", is_d ? "d" : "i");
        end
    endtask

    task automatic run_i(input int n, input int gmax);
        txn_t t;
        for (int k = 0; k < n; k++) begin
            int g = (gmax > 0) ? $urandom_range(0, gmax) : 0;
            if (g > 0) begin
                i_req = 1'b0;
                repeat (g) @(posedge clk);
                #1;
            end
            t.addr  = 32'(4 * $urandom_range(0, 255));
            t.we    = 1'b0;
            t.wdata = '0;
            t.rdata = init_val(t.addr);
            i_q.push_back(t);
            i_addr = t.addr;
            i_req  = 1'b1;
            wait_done(1'b0);
            @(posedge clk);
            #1;
        end
        i_req = 1'b0;
    endtask

    task automatic run_d(input int n, input int gmax);
        txn_t t;
        for (int k = 0; k < n; k++) begin
            int g = (gmax > 0) ? $urandom_range(0, gmax) : 0;
            if (g > 0) begin
                d_req = 1'b0;
                repeat (g) @(posedge clk);
                #1;
            end
            t.addr  = 32'h1000_0000 + 32'(4 * $urandom_range(0, 7));
            t.we    = 1'($urandom_range(0, 1));
            t.wdata = $urandom;
            t.rdata = shadow.exists(t.addr) ? shadow[t.addr] : init_val(t.addr);
            if (t.we) shadow[t.addr] = t.wdata;
            d_q.push_back(t);
            d_addr  = t.addr;
            d_we    = t.we;
            d_wdata = t.wdata;
            d_req   = 1'b1;
            wait_done(1'b1);
            @(posedge clk);
            #1;
        end
        d_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected end of test");
        $display("[TB] %0d tests run, %0d failed", tests, fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_pat;
        reset = 1'b1;
        @(posedge clk);
        #1 mon_en = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;

        // Both requesters hold requests for four back-to-back transactions.
        fork
            run_i(4, 0);
            run_d(4, 0);
        join
`ifdef MEM_ARB_RR_EN
        exp_pat = 4'b1010;
`else
        exp_pat = 4'b1111;
`endif
        if (grants.size() < 4) begin
            tests++; fail++;
            $display("FAIL tie_order: got %0d grants, expected at least 4", grants.size());
        end else begin
            chk("tie_order", {28'd0, grants[0], grants[1], grants[2], grants[3]}, {28'd0, exp_pat});
        end
        repeat (2) @(posedge clk);
        #1;

        // Reset while D owns the port; the held request must be served afterwards.
        mem_stall = 1'b1;
        fork
            run_d(1, 0);
            begin
                bit seen = 0;
                for (int c = 0; c < 50; c++) begin
                    @(negedge clk);
                    if (mem_req === 1'b1 && mem_sel === 1'b1) begin seen = 1; break; end
                end
                if (!seen) begin
                    tests++; fail++;
                    $display("FAIL rst_setup: got no D grant, expected BUSY_D");
                end
                @(posedge clk); #1 reset = 1'b1;
                @(posedge clk); #1 reset = 1'b0;
                @(negedge clk);
                chk("rst_abort_req", {31'd0, mem_req}, 32'd0);
                chk("rst_abort_done", {31'd0, d_done}, 32'd0);
                mem_stall = 1'b0;
            end
        join

        // Randomized traffic from both requesters.
        fork
            run_i(40, 3);
            run_d(40, 3);
        join

        // Stray mem_ready with nothing pending.
        repeat (2) @(posedge clk);
        #1 idle_force = 1'b1;
        repeat (8) @(posedge clk);
        #1 idle_force = 1'b0;
        repeat (2) @(posedge clk);

        chk("i_q_drained", i_q.size(), 32'd0);
        chk("d_q_drained", d_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fail);
        $finish;
    end

endmodule
